// File: rtl/mcl_pkg.sv
// mcl_pkg: shared types and constants for the MCL memory-request sequencer
package mcl_pkg;
    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_PF, S_ERR} state_t;
    localparam int RETRY_MAX_DEF = 7;
    localparam int TIMEOUT_DEF = 255;
    localparam logic [17:0] TRAP_ADDR = 18'o1777;
endpackage

// File: rtl/mcl_sat_counter.sv
// mcl_sat_counter: clear/increment counter that saturates at LIMIT and flags it
module mcl_sat_counter #(
    parameter int W = 8,
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic at_lim
);
    logic [W-1:0] cnt_q, cnt_d;
    always_comb begin
        at_lim = cnt_q == W'(LIMIT);
        cnt_d = clr ? '0 : (inc && !at_lim) ? cnt_q + 1'b1 : cnt_q;
    end
    always_ff @(posedge clk) cnt_q <= reset ? '0 : cnt_d;
endmodule

// File: rtl/mcl_mem_seq.sv
// mcl_mem_seq: EBOX memory-cycle sequencer tracking request, retry, page fail and MBOX response
module mcl_mem_seq
    import mcl_pkg::*;
#(
    parameter int RETRY_MAX = RETRY_MAX_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic memStart,
    input  logic memWrite,
    input  logic user,
    input  logic public,
    input  logic cshEBOXT0,
    input  logic cshEBOXRetry,
    input  logic mboxRespIn,
    input  logic pfEBOXHandle,
    input  logic pfClear,
    output logic eboxReqIn,
    output logic eboxSync,
    output logic mboxXfer,
    output logic pfHold,
    output logic force1777,
    output logic ptPublic,
    output logic ptWrite,
    output logic seqErr
);
    state_t state_q, state_d;
    logic xfer_q, xfer_d, ppub_q, ppub_d, pwr_q, pwr_d, user_q, user_d;
    logic start, in_wait, rty_lim, tmo_lim, tmo_clr, tmo_inc, rty_inc, unused;
    always_comb begin
        start = state_q == S_IDLE && memStart;
        in_wait = state_q == S_WAIT && !pfEBOXHandle;
        rty_inc = in_wait && cshEBOXRetry;
        tmo_clr = state_q == S_REQ && !pfEBOXHandle && cshEBOXT0;
        tmo_inc = in_wait && !cshEBOXRetry && !mboxRespIn;
        xfer_d = in_wait && !cshEBOXRetry && mboxRespIn;
        {pwr_d, ppub_d, user_d} = start ? {memWrite, public, user} : {pwr_q, ppub_q, user_q};
    end
    // timeout limit is one below TIMEOUT so ERR is entered on the TIMEOUT-th idle WAIT cycle
    mcl_sat_counter #(.W($clog2(RETRY_MAX + 1)), .LIMIT(RETRY_MAX)) u_rty (
        .clk(clk), .reset(reset), .clr(start), .inc(rty_inc), .at_lim(rty_lim)
    );
    mcl_sat_counter #(.W($clog2(TIMEOUT + 1)), .LIMIT(TIMEOUT - 1)) u_tmo (
        .clk(clk), .reset(reset), .clr(tmo_clr), .inc(tmo_inc), .at_lim(tmo_lim)
    );
    always_ff @(posedge clk) begin
        state_q <= reset ? S_IDLE : state_d;
        xfer_q <= reset ? 1'b0 : xfer_d;
        ppub_q <= reset ? 1'b0 : ppub_d;
        pwr_q <= reset ? 1'b0 : pwr_d;
        user_q <= reset ? 1'b0 : user_d;
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: state_d = memStart ? S_REQ : S_IDLE;
            S_REQ: state_d = pfEBOXHandle ? S_PF : cshEBOXT0 ? S_WAIT : S_REQ;
            S_WAIT: state_d = pfEBOXHandle ? S_PF
                            : cshEBOXRetry ? (rty_lim ? S_ERR : S_REQ)
                            : mboxRespIn ? S_IDLE
                            : tmo_lim ? S_ERR : S_WAIT;
            S_PF: state_d = pfClear ? S_IDLE : S_PF;
            default: state_d = S_ERR;
        endcase
    end
    always_comb begin
        eboxReqIn = state_q == S_REQ;
        eboxSync = state_q == S_REQ || state_q == S_WAIT;
        pfHold = state_q == S_PF;
        force1777 = state_q == S_PF;
        seqErr = state_q == S_ERR;
        mboxXfer = xfer_q;
        ptPublic = ppub_q;
        ptWrite = pwr_q;
        unused = user_q;
    end
endmodule

// File: tb/tb_mcl_mem_seq.sv
// tb_mcl_mem_seq: directed vectors with a scoreboard queue checked by a per-cycle monitor
module tb_mcl_mem_seq;
    logic clk = 0, reset, memStart, memWrite, user, public;
    logic cshEBOXT0, cshEBOXRetry, mboxRespIn, pfEBOXHandle, pfClear;
    logic eboxReqIn, eboxSync, mboxXfer, pfHold, force1777, ptPublic, ptWrite, seqErr;
    typedef struct {logic [7:0] exp; string name;} sb_t;
    sb_t sb[$];
    int n_vec = 0, n_miss = 0;
    localparam logic [9:0] RS = 10'h200, MS = 10'h100, MW = 10'h080, US = 10'h040, PB = 10'h020,
                           T0 = 10'h010, RT = 10'h008, RP = 10'h004, PF = 10'h002, PC = 10'h001;
    localparam logic [7:0] RQ = 8'h80, SY = 8'h40, XF = 8'h20, PH = 8'h10, F7 = 8'h08,
                           PP = 8'h04, PW = 8'h02, ER = 8'h01;

    mcl_mem_seq #(.RETRY_MAX(7), .TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .memStart(memStart), .memWrite(memWrite), .user(user),
        .public(public), .cshEBOXT0(cshEBOXT0), .cshEBOXRetry(cshEBOXRetry),
        .mboxRespIn(mboxRespIn), .pfEBOXHandle(pfEBOXHandle), .pfClear(pfClear),
        .eboxReqIn(eboxReqIn), .eboxSync(eboxSync), .mboxXfer(mboxXfer), .pfHold(pfHold),
        .force1777(force1777), .ptPublic(ptPublic), .ptWrite(ptWrite), .seqErr(seqErr)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            sb_t e;
            logic [7:0] got;
            e = sb.pop_front();
            got = {eboxReqIn, eboxSync, mboxXfer, pfHold, force1777, ptPublic, ptWrite, seqErr};
            n_vec++;
            if (got !== e.exp) begin
                n_miss++;
                $display("FAIL %s: outputs got %08b expected %08b (req sync xfer pfh f1777 pub wr err)",
                         e.name, got, e.exp);
            end
        end
    end

    task automatic step(input logic [9:0] v, input logic [7:0] exp, input string name);
        @(negedge clk);
        #1;
        {reset, memStart, memWrite, user, public, cshEBOXT0, cshEBOXRetry, mboxRespIn,
         pfEBOXHandle, pfClear} = v;
        sb.push_back('{exp, name});
    endtask

    initial begin
        {reset, memStart, memWrite, user, public, cshEBOXT0, cshEBOXRetry, mboxRespIn,
         pfEBOXHandle, pfClear} = RS;
        step(RS, 8'h00, "reset0");
        step(RS, 8'h00, "reset1");
        step(MS | PB | US, RQ | SY | PP, "rd_req");
        step(T0, SY | PP, "rd_t0");
        step(10'h0, SY | PP, "rd_wait1");
        step(10'h0, SY | PP, "rd_wait2");
        step(10'h0, SY | PP, "rd_wait3");
        step(RP, XF | PP, "rd_xfer");
        step(10'h0, PP, "rd_idle");
        step(MS | MW, RQ | SY | PW, "rt_req");
        step(T0, SY | PW, "rt_t0a");
        step(RT, RQ | SY | PW, "rt_retry1");
        step(T0, SY | PW, "rt_t0b");
        step(RT, RQ | SY | PW, "rt_retry2");
        step(T0, SY | PW, "rt_t0c");
        step(RP | MS | PB, XF | PW, "rt_xfer_start_ignored");
        step(10'h0, PW, "rt_idle");
        step(MS, RQ | SY, "pf_req");
        step(T0, SY, "pf_t0");
        step(PF | RP, PH | F7, "pf_beats_resp");
        step(MS, PH | F7, "pf_start_ignored");
        step(PC, 8'h00, "pf_clear");
        step(10'h0, 8'h00, "pf_idle");
        step(MS | PB, RQ | SY | PP, "pfr_req");
        step(PF | T0, PH | F7 | PP, "pfr_beats_t0");
        step(PC, PP, "pfr_clear");
        step(MS, RQ | SY, "to_req");
        step(T0, SY, "to_t0");
        step(10'h0, SY, "to_wait1");
        step(10'h0, SY, "to_wait2");
        step(10'h0, SY, "to_wait3");
        step(10'h0, ER, "to_err");
        step(MS | MW, ER, "to_start_ignored");
        step(RS, 8'h00, "to_reset");
        step(MS | MW, RQ | SY | PW, "ov_req");
        for (int i = 1; i <= 7; i++) begin
            step(T0, SY | PW, $sformatf("ov_t0_%0d", i));
            step(RT, RQ | SY | PW, $sformatf("ov_retry_%0d", i));
        end
        step(T0, SY | PW, "ov_t0_8");
        step(RT, ER | PW, "ov_retry_8_err");
        step(MS | PB, ER | PW, "ov_start_ignored");
        step(RP, ER | PW, "ov_no_xfer");
        step(RS, 8'h00, "ov_reset");
        step(MS | PB, RQ | SY | PP, "mr_req");
        step(T0, SY | PP, "mr_t0");
        step(RS, 8'h00, "mr_reset");
        step(RP, 8'h00, "mr_late_resp");
        step(10'h0, 8'h00, "mr_idle");
        repeat (3) @(negedge clk);
        #2;
        if (sb.size() != 0) begin
            n_miss++;
            $display("FAIL drain: %0d unchecked vectors left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
